// File: rtl/id_scoreboard_pkg.sv
// Shared widths and the forward-select result type for the decode operand-hazard unit.
package id_scoreboard_pkg;

   localparam int SB_NREG    = 32;
   localparam int REG_W      = 5;
   localparam int DATA_W     = 32;
   // One forward source as a producer sees it: valid, data_ok, dest, data.
   localparam int FWD_SRC_WD = 1 + 1 + REG_W + DATA_W;

   typedef struct packed {
      logic              hit;
      logic              ok;
      logic [DATA_W-1:0] data;
   } fwd_sel_t;

endpackage

// File: rtl/id_fwd_sel.sv
// Priority match of one decode operand against NFWD forward sources; index 0 (youngest) wins.
module id_fwd_sel
   import id_scoreboard_pkg::*;
#(
   parameter int NFWD = 3
) (
   input  logic [REG_W-1:0]       raddr,
   input  logic [NFWD-1:0]        fwd_valid,
   input  logic [NFWD-1:0]        fwd_data_ok,
   input  logic [REG_W*NFWD-1:0]  fwd_dest,
   input  logic [DATA_W*NFWD-1:0] fwd_data,
   output fwd_sel_t               sel
);

   // Walk oldest to youngest so the youngest match is the last one written.
   always_comb begin
      sel = '0;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_dest[i*REG_W +: REG_W] == raddr)) begin
            sel.hit  = 1'b1;
            sel.ok   = fwd_data_ok[i];
            sel.data = fwd_data[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/id_scoreboard.sv
// Decode operand-hazard unit: per-register pending counters, forwarding, ready_go interlock.
// Build option SB_FWD_EN enables operand forwarding; without it the unit is a pure interlock.
module id_scoreboard
   import id_scoreboard_pkg::*;
#(
   parameter int NFWD  = 3,
   parameter int CNT_W = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [REG_W-1:0]         raddr1,
   input  logic [REG_W-1:0]         raddr2,
   input  logic [DATA_W-1:0]        rf_rdata1,
   input  logic [DATA_W-1:0]        rf_rdata2,
   input  logic [NFWD-1:0]          fwd_valid,
   input  logic [NFWD-1:0]          fwd_data_ok,
   input  logic [REG_W*NFWD-1:0]    fwd_dest,
   input  logic [DATA_W*NFWD-1:0]   fwd_data,
   input  logic                     issue_fire,
   input  logic                     issue_we,
   input  logic [REG_W-1:0]         issue_dest,
   input  logic                     retire_we,
   input  logic [REG_W-1:0]         retire_dest,
   input  logic                     flush_all,
   input  logic                     ds_valid_in,
   output logic [DATA_W-1:0]        rs1_value,
   output logic [DATA_W-1:0]        rs2_value,
   output logic                     ready_go,
   output logic [31:0]              stall_cnt
);

   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   // Handshake: ready_go is the decode-side ready; issue_fire is the valid&&ready
   // transfer and may only be raised in a cycle where ready_go is 1.

   logic [CNT_W-1:0] pend [SB_NREG];
   fwd_sel_t         sel1, sel2;
   logic             res1, res2;

   id_fwd_sel #(.NFWD(NFWD)) u_sel1 (
      .raddr(raddr1), .fwd_valid(fwd_valid), .fwd_data_ok(fwd_data_ok),
      .fwd_dest(fwd_dest), .fwd_data(fwd_data), .sel(sel1)
   );

   id_fwd_sel #(.NFWD(NFWD)) u_sel2 (
      .raddr(raddr2), .fwd_valid(fwd_valid), .fwd_data_ok(fwd_data_ok),
      .fwd_dest(fwd_dest), .fwd_data(fwd_data), .sel(sel2)
   );

`ifdef SB_FWD_EN
   always_comb begin
      res1      = 1'b1;
      rs1_value = '0;
      if (raddr1 != '0) begin
         res1      = sel1.hit ? sel1.ok : (pend[raddr1] == '0);
         rs1_value = sel1.hit ? sel1.data : rf_rdata1;
      end
      res2      = 1'b1;
      rs2_value = '0;
      if (raddr2 != '0) begin
         res2      = sel2.hit ? sel2.ok : (pend[raddr2] == '0);
         rs2_value = sel2.hit ? sel2.data : rf_rdata2;
      end
   end
`else
   // A forward hit still means a writer is in flight, so it blocks just like pend.
   logic unused_fwd;
   assign unused_fwd = ^{sel1.ok, sel1.data, sel2.ok, sel2.data};

   always_comb begin
      res1      = (raddr1 == '0) || (!sel1.hit && (pend[raddr1] == '0));
      rs1_value = (raddr1 == '0) ? '0 : rf_rdata1;
      res2      = (raddr2 == '0) || (!sel2.hit && (pend[raddr2] == '0));
      rs2_value = (raddr2 == '0) ? '0 : rf_rdata2;
   end
`endif

   assign ready_go = res1 && res2 && !(issue_we && (pend[issue_dest] == PEND_MAX));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < SB_NREG; r++) pend[r] <= '0;
      end else if (flush_all) begin
         for (int r = 0; r < SB_NREG; r++) pend[r] <= '0;
      end else begin
         // pend[0] is never written, so it stays at its reset value of zero.
         for (int r = 1; r < SB_NREG; r++) begin
            if (issue_fire && issue_we && (issue_dest == REG_W'(r)) &&
                !(retire_we && (retire_dest == REG_W'(r))) && (pend[r] != PEND_MAX))
               pend[r] <= pend[r] + 1'b1;
            else if (retire_we && (retire_dest == REG_W'(r)) &&
                     !(issue_fire && issue_we && (issue_dest == REG_W'(r))) && (pend[r] != '0))
               pend[r] <= pend[r] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         stall_cnt <= '0;
      else if (ds_valid_in && !ready_go && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (resetn && !flush_all && retire_we && (retire_dest != '0) &&
          !(issue_fire && issue_we && (issue_dest == retire_dest)))
         assert (pend[retire_dest] != '0)
            else $error("id_scoreboard: retire of r%0d with no pending writer", retire_dest);
   end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard; works in both the SB_FWD_EN and interlock-only builds.
module tb_id_scoreboard;

   localparam int NFWD  = 3;
   localparam int CNT_W = 2;
   localparam int PMAX  = (1 << CNT_W) - 1;

   logic              clk;
   logic              resetn;
   logic [4:0]        raddr1, raddr2;
   logic [31:0]       rf_rdata1, rf_rdata2;
   logic [NFWD-1:0]   fwd_valid, fwd_data_ok;
   logic [5*NFWD-1:0] fwd_dest;
   logic [32*NFWD-1:0] fwd_data;
   logic              issue_fire, issue_we, retire_we, flush_all, ds_valid_in;
   logic [4:0]        issue_dest, retire_dest;
   logic [31:0]       rs1_value, rs2_value, stall_cnt;
   logic              ready_go;

   id_scoreboard #(.NFWD(NFWD), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetn(resetn),
      .raddr1(raddr1), .raddr2(raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .fwd_valid(fwd_valid), .fwd_data_ok(fwd_data_ok), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .issue_fire(issue_fire), .issue_we(issue_we), .issue_dest(issue_dest),
      .retire_we(retire_we), .retire_dest(retire_dest), .flush_all(flush_all),
      .ds_valid_in(ds_valid_in),
      .rs1_value(rs1_value), .rs2_value(rs2_value), .ready_go(ready_go), .stall_cnt(stall_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   // entry: {res1, val1, res2, val2, ready_go}
   logic [66:0] exp_q[$];
   int          pend_m [32];
   logic [31:0] stall_m;
   logic        rg_e;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // {resolved, value} of one operand as the hazard rules describe it.
   function automatic logic [32:0] model_op(input logic [4:0] ra, input logic [31:0] rf);
      if (ra == 5'd0) return {1'b1, 32'h0};
      for (int i = 0; i < NFWD; i++) begin
         if (fwd_valid[i] && fwd_dest[i*5 +: 5] == ra) begin
`ifdef SB_FWD_EN
            return {fwd_data_ok[i], fwd_data[i*32 +: 32]};
`else
            return {1'b0, rf};
`endif
         end
      end
      return {(pend_m[ra] == 0), rf};
   endfunction

   function automatic logic model_rg();
      logic [32:0] a, b;
      a = model_op(raddr1, rf_rdata1);
      b = model_op(raddr2, rf_rdata2);
      return a[32] && b[32] && !(issue_we && pend_m[issue_dest] == PMAX);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) pend_m[r] = 0;
      stall_m = '0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      raddr1 = '0; raddr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
      fwd_valid = '0; fwd_data_ok = '0; fwd_dest = '0; fwd_data = '0;
      issue_fire = 0; issue_we = 0; issue_dest = '0;
      retire_we = 0; retire_dest = '0; flush_all = 0; ds_valid_in = 0;
   endtask

   task automatic set_fwd(input int i, input logic v, input logic ok,
                          input logic [4:0] d, input logic [31:0] data);
      fwd_valid[i] = v; fwd_data_ok[i] = ok;
      fwd_dest[i*5 +: 5] = d; fwd_data[i*32 +: 32] = data;
   endtask

   // One cycle: push expectation and compare at negedge, advance model at posedge.
   task automatic tick(input string tag);
      logic [32:0] e1, e2;
      logic [66:0] item;
      @(negedge clk);
      e1 = model_op(raddr1, rf_rdata1);
      e2 = model_op(raddr2, rf_rdata2);
      rg_e = model_rg();
      exp_q.push_back({e1, e2, rg_e});
      item = exp_q.pop_front();
      check({tag, ".ready_go"}, ready_go, item[0]);
      if (item[66]) check({tag, ".rs1"}, rs1_value, item[65:34]);
      if (item[33]) check({tag, ".rs2"}, rs2_value, item[32:1]);
      check({tag, ".stall_cnt"}, stall_cnt, stall_m);
      @(posedge clk);
      if (ds_valid_in && !rg_e && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (flush_all) begin
         for (int r = 0; r < 32; r++) pend_m[r] = 0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            logic inc, dec;
            inc = issue_fire && issue_we && issue_dest == 5'(r);
            dec = retire_we && retire_dest == 5'(r);
            if (inc && !dec && pend_m[r] < PMAX) pend_m[r]++;
            else if (dec && !inc && pend_m[r] > 0) pend_m[r]--;
         end
      end
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      model_reset();
      resetn = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.stall_cnt", stall_cnt, 32'd0);
      check("reset.ready_go", ready_go, 32'd1);
      resetn = 1;

      // regfile path, nothing pending
      raddr1 = 5'd3; rf_rdata1 = 32'h11; ds_valid_in = 1;
      #1;
      check("t1.rs1", rs1_value, 32'h11);
      check("t1.ready_go", ready_go, 32'd1);
      tick("t1");

      // forward priority: youngest wins, an unready youngest blocks the older one
      raddr2 = 5'd5; rf_rdata2 = 32'h22;
      set_fwd(0, 1, 1, 5'd5, 32'hAA);
      set_fwd(1, 1, 1, 5'd5, 32'hBB);
      tick("t2_ok");
      set_fwd(0, 1, 0, 5'd5, 32'hAA);
      #1;
      check("t2_notok.ready_go", ready_go, 32'd0);
      tick("t2_notok");

      // r0 ignores a matching forward source
      idle_inputs(); ds_valid_in = 1;
      set_fwd(0, 1, 1, 5'd0, 32'h55);
      #1;
      check("t5.rs1", rs1_value, 32'd0);
      check("t5.ready_go", ready_go, 32'd1);
      tick("t5");

      // multicycle producer out of forwarding reach
      idle_inputs(); ds_valid_in = 1;
      raddr1 = 5'd1; rf_rdata1 = 32'h1;
      issue_we = 1; issue_dest = 5'd7; issue_fire = 1;
      tick("t3_issue");
      idle_inputs(); ds_valid_in = 1;
      raddr1 = 5'd7; rf_rdata1 = 32'h70;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t3_wait.ready_go", ready_go, 32'd0);
         tick("t3_wait");
      end
      retire_we = 1; retire_dest = 5'd7;
      set_fwd(2, 1, 1, 5'd7, 32'h77);
      tick("t3_retire");
      retire_we = 0; fwd_valid = '0;
      #1;
      check("t3_after.ready_go", ready_go, 32'd1);
      tick("t3_after");

      // saturation of a CNT_W=2 counter
      idle_inputs(); ds_valid_in = 1;
      issue_we = 1; issue_dest = 5'd9; issue_fire = 1;
      repeat (3) tick("t4_fill");
      issue_fire = 0;
      #1;
      check("t4_sat.ready_go", ready_go, 32'd0);
      tick("t4_sat");
      issue_fire = 1; retire_we = 1; retire_dest = 5'd9;
      tick("t4_both");
      issue_fire = 0; retire_we = 0;
      #1;
      check("t4_hold.ready_go", ready_go, 32'd0);
      tick("t4_hold");
      issue_we = 0; retire_we = 1;
      tick("t4_ret");
      issue_we = 1; retire_we = 0;
      #1;
      check("t4_desat.ready_go", ready_go, 32'd1);
      tick("t4_desat");
      issue_we = 0; retire_we = 1;
      repeat (2) tick("t4_drain");

      // flush beats a same-cycle retire
      idle_inputs(); ds_valid_in = 1;
      issue_we = 1; issue_dest = 5'd4; issue_fire = 1;
      repeat (2) tick("t6_issue");
      issue_fire = 0; issue_we = 0;
      flush_all = 1; retire_we = 1; retire_dest = 5'd4;
      tick("t6_flush");
      idle_inputs(); ds_valid_in = 1; raddr1 = 5'd4;
      #1;
      check("t6_after.ready_go", ready_go, 32'd1);
      tick("t6_after");

      // asynchronous reset in the middle of a stall
      issue_we = 1; issue_dest = 5'd7; issue_fire = 1; raddr1 = 5'd1;
      tick("t7_issue");
      issue_fire = 0; issue_we = 0; raddr1 = 5'd7;
      repeat (2) tick("t7_stall");
      #2;
      resetn = 0;
      #1;
      check("t7_async.stall_cnt", stall_cnt, 32'd0);
      check("t7_async.ready_go", ready_go, 32'd1);
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1;
      tick("t7_after");

      // constrained random traffic
      for (int c = 0; c < 400; c++) begin
         idle_inputs();
         ds_valid_in = ($urandom_range(0, 3) != 0);
         raddr1 = 5'($urandom_range(0, 7));
         raddr2 = 5'($urandom_range(0, 7));
         rf_rdata1 = $urandom; rf_rdata2 = $urandom;
         for (int i = 0; i < NFWD; i++)
            set_fwd(i, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0),
                    5'($urandom_range(0, 7)), $urandom);
         begin
            int rr;
            rr = $urandom_range(1, 7);
            if (pend_m[rr] != 0 && $urandom_range(0, 1) == 1) begin
               retire_we = 1; retire_dest = 5'(rr);
            end
         end
         issue_we = ($urandom_range(0, 1) == 1);
         issue_dest = 5'($urandom_range(0, 7));
         issue_fire = model_rg() && ($urandom_range(0, 1) == 1);
         flush_all = ($urandom_range(0, 39) == 0);
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
